muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV64M multiply/divide operations in the execute stage.
- Accepts one operation from decode, iterates a shared radix-2 shift-add / restoring-divide datapath one bit per cycle, and holds the result until the execute pipeline register consumes it.
- Drives the execute-stage stall while an operation is in flight.
- Supports flush on branch redirect.

---
 rtl/muldiv_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: one radix-2 shift-add or
// restoring-divide step per cycle, result held until the execute stage takes it.
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            ack_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    // Handshake: start_i is taken only in IDLE when flush_i is low; done_o then
    // holds result_o stable until a cycle with ack_i or flush_i releases it.

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            mul_q, mul_d;
    logic            w_q, w_d;
    logic            rem_sel_q, rem_sel_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Operation decode and operand preparation
    logic            accept;
    logic            dec_mul, dec_w, dec_signed, dec_rem, dec_legal;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
    logic            a_neg, b_neg, div_zero, ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        accept     = (state_q == S_IDLE) && start_i && !flush_i;
        dec_mul    = (op_i == 4'd0) || (op_i == 4'd1);
        dec_w      = op_i inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
        dec_signed = op_i inside {4'd2, 4'd4, 4'd6, 4'd8};
        dec_rem    = op_i inside {4'd4, 4'd5, 4'd8, 4'd9};
        dec_legal  = (op_i <= 4'd9);

        if (dec_w) begin
            a_ext = dec_signed ? sext32(a_i[31:0]) : {{(XLEN-32){1'b0}}, a_i[31:0]};
            b_ext = dec_signed ? sext32(b_i[31:0]) : {{(XLEN-32){1'b0}}, b_i[31:0]};
        end else begin
            a_ext = a_i;
            b_ext = b_i;
        end

        a_neg = dec_signed && a_ext[XLEN-1];
        b_neg = dec_signed && b_ext[XLEN-1];
        a_abs = a_neg ? -a_ext : a_ext;
        b_abs = b_neg ? -b_ext : b_ext;

        min_neg  = dec_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = !dec_mul && (b_ext == '0);
        ovf      = !dec_mul && dec_signed && (a_ext == min_neg) && (b_ext == '1);
        special  = !dec_legal || div_zero || ovf;

        if (!dec_legal) begin
            special_res = '0;
        end else if (div_zero) begin
            special_res = dec_rem ? (dec_w ? sext32(a_ext[31:0]) : a_ext) : '1;
        end else begin
            special_res = dec_rem ? '0 : a_ext;
        end
    end

    // One iteration of the shared datapath plus the final sign fix-up
    logic [XLEN:0]   shifted, diff;
    logic            qbit;
    logic [XLEN-1:0] it_acc, it_opa, it_opb, it_prem;
    logic [XLEN-1:0] q_fix, r_fix, raw_res, final_res;

    always_comb begin
        shifted = {prem_q, acc_q[XLEN-1]};
        diff    = shifted - {1'b0, opb_q};
        qbit    = !diff[XLEN];

        if (mul_q) begin
            it_acc  = acc_q + (opa_q[0] ? opb_q : '0);
            it_opb  = opb_q << 1;
            it_prem = prem_q;
        end else begin
            it_acc  = {acc_q[XLEN-2:0], qbit};
            it_opb  = opb_q;
            it_prem = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        end
        it_opa = opa_q >> 1;

        q_fix     = negq_q ? -it_acc : it_acc;
        r_fix     = negr_q ? -it_prem : it_prem;
        raw_res   = mul_q ? it_acc : (rem_sel_q ? r_fix : q_fix);
        final_res = w_q ? sext32(raw_res[31:0]) : raw_res;
    end

    always_comb begin
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        mul_d     = mul_q;
        w_d       = w_q;
        rem_sel_d = rem_sel_q;
        negq_d    = negq_q;
        negr_d    = negr_q;

        if (accept) begin
            mul_d     = dec_mul;
            w_d       = dec_w;
            rem_sel_d = dec_rem;
            negq_d    = a_neg ^ b_neg;
            negr_d    = a_neg;
            prem_d    = '0;
            cnt_d     = dec_w ? CW'(32) : CW'(XLEN);
            if (dec_mul) begin
                acc_d = '0;
                opb_d = a_ext;
                opa_d = b_ext;
            end else begin
                // W divides start with the 32-bit dividend in the top half so
                // 32 shifts walk all of its bits into the partial remainder.
                acc_d = dec_w ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
                opb_d = b_abs;
                opa_d = '0;
            end
            if (special) begin
                result_d = special_res;
                cnt_d    = '0;
            end
        end else if (state_q == S_CALC) begin
            if (flush_i) begin
                cnt_d = '0;
            end else begin
                acc_d  = it_acc;
                opa_d  = it_opa;
                opb_d  = it_opb;
                prem_d = it_prem;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            mul_q     <= 1'b0;
            w_q       <= 1'b0;
            rem_sel_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            mul_q     <= mul_d;
            w_q       <= w_d;
            rem_sel_q <= rem_sel_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        stall_o     = accept || (state_q == S_CALC);
        done_o      = (state_q == S_DONE);
        result_o    = result_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed cases plus random ops checked
// against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  op_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        flush_i;
    logic        ack_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic done_prev = 1'b0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    muldiv_seq #(.XLEN(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .flush_i    (flush_i),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV64M rules
    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        int sa32, sb32;
        int unsigned ua32, ub32;
        logic [31:0] r32;
        sa = a; sb = b;
        sa32 = a[31:0]; sb32 = b[31:0];
        ua32 = a[31:0]; ub32 = b[31:0];
        case (op)
            4'd0: return a * b;
            4'd1: begin r32 = a[31:0] * b[31:0]; return sx32(r32); end
            4'd2: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return a;
                return sa / sb;
            end
            4'd3: return (b == 0) ? '1 : a / b;
            4'd4: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return '0;
                return sa % sb;
            end
            4'd5: return (b == 0) ? a : a % b;
            4'd6: begin
                if (sb32 == 0) r32 = '1;
                else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = sa32;
                else r32 = sa32 / sb32;
                return sx32(r32);
            end
            4'd7: begin r32 = (ub32 == 0) ? '1 : ua32 / ub32; return sx32(r32); end
            4'd8: begin
                if (sb32 == 0) r32 = sa32;
                else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = '0;
                else r32 = sa32 % sb32;
                return sx32(r32);
            end
            4'd9: begin r32 = (ub32 == 0) ? ua32 : ua32 % ub32; return sx32(r32); end
            default: return '0;
        endcase
    endfunction

    // Edges from the accepting edge (counted as 1) until done_o is visible
    function automatic int exp_latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit is_w, is_s, bz, ov;
        if (op > 4'd9) return 1;
        is_w = op inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
        if (op <= 4'd1) return is_w ? 33 : 65;
        is_s = op inside {4'd2, 4'd4, 4'd6, 4'd8};
        bz = is_w ? (b[31:0] == 0) : (b == 0);
        ov = is_s && (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == MIN64 && b == '1));
        if (bz || ov) return 1;
        return is_w ? 33 : 65;
    endfunction

    // Monitor: each rising done_o consumes one scoreboard entry
    initial begin
        forever begin
            @(negedge clk);
            if (done_o && !done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: result %h with no expected entry", result_o);
                end else begin
                    check("result", result_o, exp_q.pop_front());
                end
            end
            done_prev = done_o;
        end
    end

    // Driver tasks
    task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int ack_delay, input bit release_by_flush);
        int lat, stall_cnt, edges;
        lat = exp_latency(op, a, b);
        @(negedge clk);
        exp_q.push_back(exp);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        @(negedge clk);
        start_i = 1'b0;
        op_i = 4'($urandom);
        a_i = {$urandom, $urandom};
        b_i = {$urandom, $urandom};
        edges = 1;
        while (!done_o && edges < 100) begin
            if (stall_o) stall_cnt++;
            @(negedge clk);
            edges++;
        end
        check("latency", 64'(edges), 64'(lat));
        check("stall_cycles", 64'(stall_cnt), 64'(lat));
        for (int i = 0; i < ack_delay; i++) begin
            start_i = 1'b1;
            op_i = 4'd0;
            check("hold_done", 64'(done_o), 64'd1);
            check("hold_result", result_o, exp);
            @(negedge clk);
        end
        start_i = 1'b0;
        if (release_by_flush) flush_i = 1'b1;
        else ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        flush_i = 1'b0;
        check("release_idle", {62'd0, busy_o, done_o}, 64'd0);
    endtask

    task automatic flush_test(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input int at_cycle);
        int seen;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        repeat (at_cycle - 1) @(negedge clk);
        check("flush_busy_before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_idle", {61'd0, busy_o, done_o, stall_o}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check("flush_no_done", 64'(seen), 64'd0);
    endtask

    task automatic reset_test(input int at_cycle);
        @(negedge clk);
        start_i = 1'b1; op_i = 4'd0; a_i = 64'd123; b_i = 64'd456;
        @(negedge clk);
        start_i = 1'b0;
        repeat (at_cycle - 1) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", {61'd0, busy_o, done_o, stall_o}, 64'd0);
        check("reset_mid_result", result_o, 64'd0);
        check("reset_mid_state", 64'(dbg_state_o), 64'd0);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        check("reset_no_done", 64'(done_o), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return MIN64;
            4: return 64'($urandom_range(0, 100));
            5: return {$urandom, 32'h8000_0000};
            6: return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        reset = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        flush_i = 1'b0; ack_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {61'd0, busy_o, done_o, stall_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0);
        do_op(4'd2, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
        do_op(4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0);
        do_op(4'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        do_op(4'd5, 64'd5, 64'd0, 64'd5, 0, 1'b0);
        do_op(4'd2, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 0, 1'b0);
        do_op(4'd4, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1'b0);
        do_op(4'd7, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 0, 1'b0);
        do_op(4'd1, 64'h10000, 64'h10000, 64'd0, 0, 1'b0);
        do_op(4'd1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0);
        do_op(4'd3, 64'd100, 64'd7, 64'd14, 3, 1'b0);
        do_op(4'd12, 64'd9, 64'd3, 64'd0, 1, 1'b1);

        flush_test(4'd2, 64'd1000, 64'd7, 10);
        reset_test(20);

        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 4'd0; a_i = 64'd3; b_i = 64'd4;
        #1;
        check("start_flush_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check("start_flush_idle", 64'(busy_o), 64'd0);
        repeat (70) @(negedge clk);
        check("start_flush_no_done", 64'(done_o), 64'd0);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 11));
            a = pick();
            b = pick();
            do_op(op, a, b, model(op, a, b), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
